mdu_seq: RTL

Multi-cycle multiply/divide sequencer that sits beside the execute stage and serves RV32M operations the single-cycle ALU cannot compute. The execute stage issues one operation over a valid/ready request channel and holds its `ready_go` low until the result returns on a valid/ready response channel. A branch-predictor flush aborts any in-flight operation.

---
 rtl/mdu_seq_pkg.sv | 32 +++
 rtl/mdu_div_step.sv | 23 ++
 rtl/mdu_seq.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mdu_seq_pkg.sv
// Shared encodings for the multiply/divide sequencer: RV32M op codes, FSM states
// and operand-sign decode helpers.
package mdu_seq_pkg;

    localparam int MDU_OP_LENGTH = 3;

    localparam logic [MDU_OP_LENGTH-1:0] MDU_OP_MUL    = 3'd0;
    localparam logic [MDU_OP_LENGTH-1:0] MDU_OP_MULH   = 3'd1;
    localparam logic [MDU_OP_LENGTH-1:0] MDU_OP_MULHSU = 3'd2;
    localparam logic [MDU_OP_LENGTH-1:0] MDU_OP_MULHU  = 3'd3;
    localparam logic [MDU_OP_LENGTH-1:0] MDU_OP_DIV    = 3'd4;
    localparam logic [MDU_OP_LENGTH-1:0] MDU_OP_DIVU   = 3'd5;
    localparam logic [MDU_OP_LENGTH-1:0] MDU_OP_REM    = 3'd6;
    localparam logic [MDU_OP_LENGTH-1:0] MDU_OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        MDU_ST_IDLE = 2'd0,
        MDU_ST_CALC = 2'd1,
        MDU_ST_DONE = 2'd2
    } mdu_state_t;

    // MUL keeps only the low half, so it can be treated as unsigned.
    function automatic logic sign_a_en(input logic [MDU_OP_LENGTH-1:0] op);
        return (op == MDU_OP_MULH) || (op == MDU_OP_MULHSU) ||
               (op == MDU_OP_DIV)  || (op == MDU_OP_REM);
    endfunction

    function automatic logic sign_b_en(input logic [MDU_OP_LENGTH-1:0] op);
        return (op == MDU_OP_MULH) || (op == MDU_OP_DIV) || (op == MDU_OP_REM);
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the
// divisor, keep the difference when it does not go negative.
module mdu_div_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH:0]   i_rem,
    input  logic                  i_bit,
    input  logic [DATA_WIDTH-1:0] i_div,
    output logic [DATA_WIDTH:0]   o_rem,
    output logic                  o_q
);

    logic [DATA_WIDTH+1:0] w_shift;
    logic [DATA_WIDTH+1:0] w_diff;

    always_comb begin
        w_shift = {i_rem, i_bit};
        w_diff  = w_shift - {2'b00, i_div};
        o_q     = ~w_diff[DATA_WIDTH+1];
        o_rem   = o_q ? w_diff[DATA_WIDTH:0] : w_shift[DATA_WIDTH:0];
    end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle RV32M multiply/divide sequencer with valid/ready request and response.
// Define MDU_FAST_MUL_EN to complete all multiplies in one cycle with a full multiplier.
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [MDU_OP_LENGTH-1:0] req_op,
    input  logic [DATA_WIDTH-1:0]    req_a,
    input  logic [DATA_WIDTH-1:0]    req_b,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [DATA_WIDTH-1:0]    resp_data,
    output logic                     busy
);

    localparam logic [5:0] CNT_LAST = 6'(DATA_WIDTH - 1);

    mdu_state_t                r_state, w_state_next;
    logic [MDU_OP_LENGTH-1:0]  r_op;
    logic [5:0]                r_cnt;
    logic [DATA_WIDTH:0]       r_hi;
    logic [DATA_WIDTH-1:0]     r_lo;
    logic [DATA_WIDTH-1:0]     r_b;
    logic                      r_neg_q;
    logic                      r_neg_r;
    logic [DATA_WIDTH-1:0]     r_data;

    logic                      w_accept, w_last, w_fast, w_skip;
    logic                      w_a_neg, w_b_neg, w_div_zero, w_ovf, w_special;
    logic [DATA_WIDTH-1:0]     w_abs_a, w_abs_b, w_special_data;
    logic [DATA_WIDTH:0]       w_sum, w_div_rem, w_hi_next;
    logic                      w_div_q;
    logic [DATA_WIDTH-1:0]     w_lo_next, w_quo_s, w_rem_s, w_result;
    logic [2*DATA_WIDTH-1:0]   w_prod, w_prod_s;

    assign w_accept   = (r_state == MDU_ST_IDLE) && req_valid && !flush;
    assign w_last     = (r_cnt == CNT_LAST);
    assign w_a_neg    = sign_a_en(req_op) && req_a[DATA_WIDTH-1];
    assign w_b_neg    = sign_b_en(req_op) && req_b[DATA_WIDTH-1];
    assign w_abs_a    = w_a_neg ? -req_a : req_a;
    assign w_abs_b    = w_b_neg ? -req_b : req_b;
    assign w_div_zero = req_op[2] && (req_b == '0);
    assign w_ovf      = ((req_op == MDU_OP_DIV) || (req_op == MDU_OP_REM)) &&
                        (req_a == {1'b1, {(DATA_WIDTH-1){1'b0}}}) && (req_b == '1);
    assign w_special  = w_div_zero || w_ovf;
    // req_op[1] selects the remainder among the divide ops.
    assign w_special_data = w_div_zero ? (req_op[1] ? req_a : '1)
                                       : (req_op[1] ? '0 : req_a);

`ifdef MDU_FAST_MUL_EN
    logic [2*DATA_WIDTH-1:0] w_fast_a, w_fast_b, w_fast_p;
    logic [DATA_WIDTH-1:0]   w_fast_data;
    assign w_fast_a    = {{DATA_WIDTH{w_a_neg}}, req_a};
    assign w_fast_b    = {{DATA_WIDTH{w_b_neg}}, req_b};
    assign w_fast_p    = w_fast_a * w_fast_b;
    assign w_fast_data = (req_op == MDU_OP_MUL) ? w_fast_p[DATA_WIDTH-1:0]
                                                : w_fast_p[2*DATA_WIDTH-1:DATA_WIDTH];
    assign w_fast      = !req_op[2];
`else
    assign w_fast      = 1'b0;
`endif
    assign w_skip = w_special || w_fast;

    // Multiply: {r_hi, r_lo} is a right-shifting accumulator, r_lo starts as the multiplier.
    // Divide: r_hi is the partial remainder, r_lo shifts dividend bits out and quotient bits in.
    mdu_div_step #(.DATA_WIDTH(DATA_WIDTH)) u_div_step (
        .i_rem (r_hi),
        .i_bit (r_lo[DATA_WIDTH-1]),
        .i_div (r_b),
        .o_rem (w_div_rem),
        .o_q   (w_div_q)
    );

    always_comb begin
        w_sum     = {1'b0, r_hi[DATA_WIDTH-1:0]} + {1'b0, (r_lo[0] ? r_b : '0)};
        w_hi_next = r_op[2] ? w_div_rem : {1'b0, w_sum[DATA_WIDTH:1]};
        w_lo_next = r_op[2] ? {r_lo[DATA_WIDTH-2:0], w_div_q} : {w_sum[0], r_lo[DATA_WIDTH-1:1]};
        w_prod    = {w_hi_next[DATA_WIDTH-1:0], w_lo_next};
        w_prod_s  = r_neg_q ? -w_prod : w_prod;
        w_quo_s   = r_neg_q ? -w_lo_next : w_lo_next;
        w_rem_s   = r_neg_r ? -w_hi_next[DATA_WIDTH-1:0] : w_hi_next[DATA_WIDTH-1:0];
        case (r_op)
            MDU_OP_MUL:                     w_result = w_prod_s[DATA_WIDTH-1:0];
            MDU_OP_MULH, MDU_OP_MULHSU,
            MDU_OP_MULHU:                   w_result = w_prod_s[2*DATA_WIDTH-1:DATA_WIDTH];
            MDU_OP_DIV, MDU_OP_DIVU:        w_result = w_quo_s;
            default:                        w_result = w_rem_s;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= MDU_ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        busy         = 1'b1;
        case (r_state)
            MDU_ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (w_accept) w_state_next = w_skip ? MDU_ST_DONE : MDU_ST_CALC;
            end
            MDU_ST_CALC: if (w_last) w_state_next = MDU_ST_DONE;
            MDU_ST_DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) w_state_next = MDU_ST_IDLE;
            end
            default:     w_state_next = MDU_ST_IDLE;
        endcase
        if (flush) w_state_next = MDU_ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op    <= '0;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_b     <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_data  <= '0;
        end else if (w_accept) begin
            r_op    <= req_op;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= req_op[2] ? w_abs_a : w_abs_b;
            r_b     <= req_op[2] ? w_abs_b : w_abs_a;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            if (w_special) r_data <= w_special_data;
`ifdef MDU_FAST_MUL_EN
            else if (w_fast) r_data <= w_fast_data;
`endif
        end else if ((r_state == MDU_ST_CALC) && !flush) begin
            r_hi  <= w_hi_next;
            r_lo  <= w_lo_next;
            r_cnt <= r_cnt + 6'd1;
            if (w_last) r_data <= w_result;
        end
    end

    assign resp_data = r_data;

endmodule
